// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults and decoder lock-state encoding.
// Also used by the sync generator, so defaults describe standard 640x480@60.
package vga_timing_pkg;

  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_TOTAL_DEF  = 800;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_TOTAL_DEF  = 525;

  typedef logic [1:0] sync_state_t;

  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  function automatic logic [10:0] inc_sat_h(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  function automatic logic [9:0] inc_sat_v(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/vga_edge_detect.sv
// Registers an active-low sync input once per pixel tick and flags its falling edge.
// The fall flag describes the sample currently held in the register.
module vga_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic pix_en,
  input  logic sync_in,
  output logic fall
);

  logic sync_q;
  logic sync_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 1'b1;
      sync_prev <= 1'b1;
    end else if (pix_en) begin
      sync_q    <= sync_in;
      sync_prev <= sync_q;
    end
  end

  assign fall = sync_prev & ~sync_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates from an incoming VGA stream and tracks timing lock.
// Stage 1 samples sync/colour; stage 2 commits counters, FSM and outputs one tick later.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_TOTAL  = H_TOTAL_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_TOTAL  = V_TOTAL_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic [7:0] red_in,
  input  logic [7:0] green_in,
  input  logic [7:0] blue_in,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic       pix_valid,
  output logic       frame_start,
  output logic       locked,
  output logic       sync_err
);

  localparam logic [10:0] H_START = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_END   = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_LIMIT = 11'(2 * H_TOTAL);
  localparam logic [9:0]  V_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  V_END   = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);

  logic        hs_fall, vs_fall;
  logic [7:0]  red_q, green_q, blue_q;
  logic [10:0] h_cnt, h_cur;
  logic [9:0]  v_cnt, v_cur;
  logic        v_armed, arm_now;
  logic        bad, bad_nxt, err_nxt;
  logic        line_bad, frame_bad, active;
  sync_state_t state, state_nxt;

  vga_edge_detect u_hs_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .pix_en (pix_en),
    .sync_in(hsync_in),
    .fall   (hs_fall)
  );

  vga_edge_detect u_vs_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .pix_en (pix_en),
    .sync_in(vsync_in),
    .fall   (vs_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else if (pix_en) begin
      red_q   <= red_in;
      green_q <= green_in;
      blue_q  <= blue_in;
    end
  end

  // h_cur/v_cur are the coordinates of the sample currently held in stage 1.
  // A vsync edge arms before the hsync edge of the same sample is processed.
  always_comb begin
    arm_now   = v_armed | vs_fall;
    h_cur     = hs_fall ? 11'd0 : inc_sat_h(h_cnt);
    v_cur     = v_cnt;
    if (hs_fall) v_cur = arm_now ? 10'd0 : inc_sat_v(v_cnt);
    line_bad  = hs_fall && (h_cnt != H_LAST);
    frame_bad = vs_fall && (v_cnt != V_LAST);
    active    = (h_cur >= H_START) && (h_cur < H_END) &&
                (v_cur >= V_START) && (v_cur < V_END);
  end

  always_comb begin
    state_nxt = state;
    bad_nxt   = bad;
    err_nxt   = 1'b0;
    if (h_cur >= H_LIMIT) begin
      state_nxt = ST_SEARCH;
      bad_nxt   = 1'b0;
    end else begin
      case (state)
        ST_SEARCH: begin
          if (vs_fall) begin
            state_nxt = ST_MEASURE;
            bad_nxt   = 1'b0;
          end
        end
        ST_MEASURE: begin
          // A line ending on the vsync edge still belongs to the frame being judged.
          if (vs_fall) begin
            if (!bad && !line_bad && (v_cnt == V_LAST)) state_nxt = ST_LOCKED;
            bad_nxt = 1'b0;
          end else if (line_bad) begin
            bad_nxt = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (line_bad || frame_bad) begin
            err_nxt   = 1'b1;
            state_nxt = ST_MEASURE;
            bad_nxt   = line_bad && !vs_fall;
          end
        end
        default: state_nxt = ST_SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      v_armed  <= 1'b0;
      bad      <= 1'b0;
      state    <= ST_SEARCH;
      locked   <= 1'b0;
      sync_err <= 1'b0;
    end else if (pix_en) begin
      h_cnt    <= h_cur;
      v_cnt    <= v_cur;
      v_armed  <= hs_fall ? 1'b0 : arm_now;
      bad      <= bad_nxt;
      state    <= state_nxt;
      locked   <= (state == ST_LOCKED);
      sync_err <= err_nxt;
    end
  end

  // x/y deliberately keep their last active values through blanking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x           <= '0;
      y           <= '0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      if (active && (state == ST_LOCKED)) begin
        x           <= 10'(h_cur - H_START);
        y           <= v_cur - V_START;
        red         <= red_q;
        green       <= green_q;
        blue        <= blue_q;
        pix_valid   <= 1'b1;
        frame_start <= (h_cur == H_START) && (v_cur == V_START);
      end else begin
        red         <= '0;
        green       <= '0;
        blue        <= '0;
        pix_valid   <= 1'b0;
        frame_start <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a reduced 48x20 raster so whole frames stay short.
// Pixel outputs after each pix_en tick are compared against the pixel driven one tick earlier.
module tb_vga_sync_decoder;

  localparam int HS = 8, HB = 4, HA = 32, HT = 48;
  localparam int VS = 2, VB = 3, VA = 10, VT = 20;
  localparam int XS = HS + HB, YS = VS + VB;

  logic       clk = 1'b0;
  logic       rst_n, pix_en, hsync_in, vsync_in;
  logic [7:0] red_in, green_in, blue_in;
  logic [9:0] x, y;
  logic [7:0] red, green, blue;
  logic       pix_valid, frame_start, locked, sync_err;

  always #5 clk = ~clk;

  vga_sync_decoder #(
    .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_TOTAL(VT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_en     (pix_en),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .red_in     (red_in),
    .green_in   (green_in),
    .blue_in    (blue_in),
    .x          (x),
    .y          (y),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .pix_valid  (pix_valid),
    .frame_start(frame_start),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  int errors = 0, checks = 0;
  int div = 1;
  int gh = 0, gv = 0, ph = HT - 1, pv = VT - 1, short_v = -1;
  bit chk = 0, exp_lock = 0, hx_known = 0, err_prev = 0;
  int hx = 0, hy = 0;
  int n_valid, n_fs, n_err, n_lock, pix_errs, bad_h, bad_v, tick_no;
  int first_x, first_y, first_fs, last_x, last_y, lk3, lock_at_err, lock_after_err;
  int hold_errs = 0;

  function automatic bit in_active(input int h, input int v);
    return (h >= XS) && (h < XS + HA) && (v >= YS) && (v < YS + VA);
  endfunction

  task automatic reset_stats();
    n_valid = 0; n_fs = 0; n_err = 0; n_lock = 0; pix_errs = 0; bad_h = -1; bad_v = -1;
    tick_no = 0; first_x = -1; first_y = -1; first_fs = -1; last_x = -1; last_y = -1;
    lk3 = -1; lock_at_err = -1; lock_after_err = -1; err_prev = 0;
  endtask

  task automatic pulse();
    logic [47:0] snap;
    pix_en = 1'b1;
    @(posedge clk); #1;
    pix_en = 1'b0;
    snap = {x, y, red, green, blue, pix_valid, frame_start, locked, sync_err};
    for (int i = 1; i < div; i++) begin
      @(posedge clk); #1;
      if ({x, y, red, green, blue, pix_valid, frame_start, locked, sync_err} !== snap)
        hold_errs++;
    end
  endtask

  task automatic step();
    logic [7:0] er, eg, eb;
    bit ev, bad;
    hsync_in = (gh < HS) ? 1'b0 : 1'b1;
    vsync_in = (gv < VS) ? 1'b0 : 1'b1;
    red_in   = 8'(gh);
    green_in = 8'(gv);
    blue_in  = 8'(gh) ^ 8'(gv);
    pulse();
    tick_no++;
    ev = exp_lock && in_active(ph, pv);
    er = 8'(ph);
    eg = 8'(pv);
    eb = er ^ eg;
    if (chk) begin
      bad = 0;
      if (pix_valid !== ev || sync_err !== 1'b0) bad = 1;
      if (ev) begin
        if (x !== 10'(ph - XS) || y !== 10'(pv - YS) || red !== er || green !== eg ||
            blue !== eb || frame_start !== (ph == XS && pv == YS)) bad = 1;
        hx = ph - XS; hy = pv - YS; hx_known = 1;
      end else begin
        if (red !== 8'd0 || green !== 8'd0 || blue !== 8'd0 || frame_start !== 1'b0) bad = 1;
        if (hx_known && (x !== 10'(hx) || y !== 10'(hy))) bad = 1;
      end
      if (bad) begin
        pix_errs++;
        if (pix_errs == 1) begin bad_h = ph; bad_v = pv; end
      end
    end else begin
      hx_known = 0;
    end
    if (pix_valid) begin
      n_valid++;
      if (n_valid == 1) begin first_x = int'(x); first_y = int'(y); first_fs = int'(frame_start); end
      last_x = int'(x); last_y = int'(y);
    end
    if (frame_start) n_fs++;
    if (locked) n_lock++;
    if (err_prev && lock_after_err < 0) lock_after_err = int'(locked);
    if (sync_err) begin
      n_err++;
      if (lock_at_err < 0) lock_at_err = int'(locked);
    end
    err_prev = sync_err;
    if (tick_no == 3) lk3 = int'(locked);
    ph = gh; pv = gv;
    gh++;
    if (gh >= ((gv == short_v) ? HT - 1 : HT)) begin
      gh = 0;
      gv = (gv + 1) % VT;
    end
  endtask

  task automatic run_frame(input bit c, input bit el);
    reset_stats();
    chk = c; exp_lock = el;
    do step(); while (!(gh == 0 && gv == 0));
  endtask

  task automatic restart_gen();
    gh = 0; gv = 0; ph = HT - 1; pv = VT - 1;
    hx = 0; hy = 0; hx_known = 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      hsync_in = i[0]; vsync_in = i[1];
      red_in = 8'($urandom); green_in = 8'($urandom); blue_in = 8'($urandom);
      pulse();
    end
    checks++; if (x !== 10'd0) begin errors++; $display("[TB] FAIL reset_x: got %0d want 0", x); end
    checks++; if (y !== 10'd0) begin errors++; $display("[TB] FAIL reset_y: got %0d want 0", y); end
    checks++; if (red !== 8'd0) begin errors++; $display("[TB] FAIL reset_red: got %0d want 0", red); end
    checks++; if (green !== 8'd0) begin errors++; $display("[TB] FAIL reset_green: got %0d want 0", green); end
    checks++; if (blue !== 8'd0) begin errors++; $display("[TB] FAIL reset_blue: got %0d want 0", blue); end
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_pix_valid: got %b want 0", pix_valid); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_start: got %b want 0", frame_start); end
    checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL reset_locked: got %b want 0", locked); end
    checks++; if (sync_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_sync_err: got %b want 0", sync_err); end
    hsync_in = 1'b1; vsync_in = 1'b1;
    rst_n = 1'b1;
    restart_gen();
  endtask

  task automatic test_lock();
    run_frame(1, 0);
    checks++; if (n_lock != 0) begin errors++; $display("[TB] FAIL lock_frame1: locked ticks %0d want 0", n_lock); end
    checks++; if (pix_errs != 0) begin errors++; $display("[TB] FAIL frame1_pixels: %0d bad (first h=%0d v=%0d) want 0", pix_errs, bad_h, bad_v); end
    run_frame(1, 1);
    checks++; if (lk3 != 1) begin errors++; $display("[TB] FAIL lock_frame2_start: locked=%0d want 1", lk3); end
    checks++; if (pix_errs != 0) begin errors++; $display("[TB] FAIL frame2_pixels: %0d bad (first h=%0d v=%0d) want 0", pix_errs, bad_h, bad_v); end
    run_frame(1, 1);
    checks++; if (n_valid != HA * VA) begin errors++; $display("[TB] FAIL frame3_valid_count: got %0d want %0d", n_valid, HA * VA); end
    checks++; if (n_fs != 1) begin errors++; $display("[TB] FAIL frame3_fs_count: got %0d want 1", n_fs); end
    checks++; if (first_x != 0 || first_y != 0 || first_fs != 1) begin errors++; $display("[TB] FAIL frame3_first: got x=%0d y=%0d fs=%0d want 0 0 1", first_x, first_y, first_fs); end
    checks++; if (last_x != HA - 1 || last_y != VA - 1) begin errors++; $display("[TB] FAIL frame3_last: got x=%0d y=%0d want %0d %0d", last_x, last_y, HA - 1, VA - 1); end
    checks++; if (pix_errs != 0) begin errors++; $display("[TB] FAIL frame3_pixels: %0d bad (first h=%0d v=%0d) want 0", pix_errs, bad_h, bad_v); end
  endtask

  task automatic test_colour_ramp();
    run_frame(1, 1);
    checks++; if (pix_errs != 0) begin errors++; $display("[TB] FAIL colour_ramp: %0d bad (first h=%0d v=%0d) want 0", pix_errs, bad_h, bad_v); end
    checks++; if (n_valid != HA * VA) begin errors++; $display("[TB] FAIL colour_valid_count: got %0d want %0d", n_valid, HA * VA); end
  endtask

  task automatic test_short_line();
    short_v = 5;
    run_frame(0, 1);
    short_v = -1;
    checks++; if (n_err != 1) begin errors++; $display("[TB] FAIL short_err_ticks: got %0d want 1", n_err); end
    checks++; if (lock_at_err != 1) begin errors++; $display("[TB] FAIL short_lock_at_err: got %0d want 1", lock_at_err); end
    checks++; if (lock_after_err != 0) begin errors++; $display("[TB] FAIL short_lock_after_err: got %0d want 0", lock_after_err); end
    run_frame(1, 0);
    checks++; if (n_lock != 0) begin errors++; $display("[TB] FAIL short_measure_frame: locked ticks %0d want 0", n_lock); end
    run_frame(1, 1);
    checks++; if (lk3 != 1) begin errors++; $display("[TB] FAIL short_relock: locked=%0d want 1", lk3); end
    checks++; if (pix_errs != 0) begin errors++; $display("[TB] FAIL short_relock_pixels: %0d bad want 0", pix_errs); end
  endtask

  task automatic test_watchdog();
    int errs, l40;
    reset_stats();
    chk = 0;
    repeat (2 * HT) step();
    hsync_in = 1'b1; vsync_in = 1'b1;
    red_in = 8'd0; green_in = 8'd0; blue_in = 8'd0;
    errs = 0; l40 = -1;
    for (int k = 1; k <= 120; k++) begin
      pulse();
      if (sync_err) errs++;
      if (k == 40) l40 = int'(locked);
    end
    checks++; if (l40 != 1) begin errors++; $display("[TB] FAIL wd_before_limit: locked=%0d want 1", l40); end
    checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL wd_locked: got %b want 0", locked); end
    checks++; if (errs != 0) begin errors++; $display("[TB] FAIL wd_sync_err: pulses %0d want 0", errs); end
    restart_gen();
    hx_known = 0;
    run_frame(1, 0);
    checks++; if (n_err != 0 || n_lock != 0) begin errors++; $display("[TB] FAIL wd_search_frame: err=%0d lock=%0d want 0 0", n_err, n_lock); end
    run_frame(1, 1);
    checks++; if (lk3 != 1) begin errors++; $display("[TB] FAIL wd_relock: locked=%0d want 1", lk3); end
  endtask

  task automatic test_reset_midline();
    reset_stats();
    chk = 1; exp_lock = 1;
    repeat (YS * HT + XS + 5) step();
    checks++; if (pix_valid !== 1'b1) begin errors++; $display("[TB] FAIL midline_valid: got %b want 1", pix_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({x, y, red, green, blue, pix_valid, frame_start, locked, sync_err} !== 48'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: x=%0d y=%0d r=%0d v=%b l=%b want all 0", x, y, red, pix_valid, locked);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    hx = 0; hy = 0; hx_known = 1;
    run_frame(1, 0);
    run_frame(1, 0);
    checks++; if (n_lock != 0) begin errors++; $display("[TB] FAIL midline_measure: locked ticks %0d want 0", n_lock); end
    run_frame(1, 1);
    checks++; if (lk3 != 1) begin errors++; $display("[TB] FAIL midline_relock: locked=%0d want 1", lk3); end
  endtask

  task automatic test_pix_div();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    div = 4;
    hold_errs = 0;
    hsync_in = 1'b1; vsync_in = 1'b1;
    restart_gen();
    run_frame(1, 0);
    run_frame(1, 1);
    checks++; if (lk3 != 1) begin errors++; $display("[TB] FAIL div_lock: locked=%0d want 1", lk3); end
    run_frame(1, 1);
    checks++; if (n_valid != HA * VA || n_fs != 1) begin errors++; $display("[TB] FAIL div_counts: valid=%0d fs=%0d want %0d 1", n_valid, n_fs, HA * VA); end
    checks++; if (first_x != 0 || first_y != 0 || first_fs != 1 || last_x != HA - 1 || last_y != VA - 1) begin
      errors++; $display("[TB] FAIL div_first_last: got %0d,%0d,%0d / %0d,%0d", first_x, first_y, first_fs, last_x, last_y);
    end
    checks++; if (pix_errs != 0) begin errors++; $display("[TB] FAIL div_pixels: %0d bad (first h=%0d v=%0d) want 0", pix_errs, bad_h, bad_v); end
    checks++; if (hold_errs != 0) begin errors++; $display("[TB] FAIL div_hold: %0d changes between ticks want 0", hold_errs); end
  endtask

  initial begin
    rst_n = 1'b0; pix_en = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    red_in = 8'd0; green_in = 8'd0; blue_in = 8'd0;
    #1;
    test_reset();
    test_lock();
    test_colour_ramp();
    test_short_line();
    test_watchdog();
    test_reset_midline();
    test_pix_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 Parameters SHALL be: H_SYNC, default 96, hsync pulse width in pixels; H_BP, default 48, horizontal back porch; H_ACTIVE, default 640, active pixels per line; H_TOTAL, default 800, pixels per line.
REQ-002 Parameters SHALL further be: V_SYNC, default 2, vsync lines; V_BP, default 33, vertical back porch; V_ACTIVE, default 480, active lines; V_TOTAL, default 525, lines per frame.
REQ-003 Ports SHALL be: clk  in  1  single system clock; all logic on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 pix_en  in  1  pixel-tick strobe; all sampling and counting advance only on clk edges where pix_en=1.
REQ-006 hsync_in, vsync_in  in  1 each  active-low sync inputs.
REQ-007 red_in, green_in, blue_in  in  8 each  pixel colour.
REQ-008 x, y  out  10 each  active-area coordinates of the output pixel.
REQ-009 red, green, blue  out  8 each  registered pixel colour.
REQ-010 pix_valid  out  1  output pixel lies in the active area and decoder is locked.
REQ-011 frame_start  out  1  high with the pixel x=0,y=0 only.
REQ-012 locked  out  1  timing lock status.
REQ-013 sync_err  out  1  one-pix_en-tick pulse on timing violation while locked.

Function
REQ-014 Sync and colour inputs SHALL be registered once per pix_en; sync edges are detected by comparing that register to its previous value.
REQ-015 An hsync falling edge SHALL reset the horizontal counter h_cnt to 0 for that pixel; otherwise h_cnt increments per pix_en, saturating at 2047.
REQ-016 A vsync falling edge SHALL arm a flag; the next hsync falling edge SHALL set v_cnt=0 and clear the flag; other hsync falling edges increment v_cnt, saturating at 1023.
REQ-017 Active area SHALL be H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACTIVE and V_SYNC+V_BP <= v_cnt < V_SYNC+V_BP+V_ACTIVE; x and y are the offsets from those start values.
REQ-018 x, y, colour, pix_valid and frame_start SHALL update on the pix_en tick after the input sample (latency one pix_en tick) and hold between ticks.
REQ-019 Outside the active area, or when not LOCKED, pix_valid SHALL be 0 and red/green/blue SHALL be 0; x and y SHALL hold their last active values.
REQ-020 FSM SHALL have states SEARCH, MEASURE, LOCKED; reset state is SEARCH.
REQ-021 SEARCH -> MEASURE on the first vsync falling edge.
REQ-022 MEASURE: each completed line whose length (h_cnt at the next hsync falling edge, plus 1) differs from H_TOTAL sets a bad flag; at the next vsync falling edge, go to LOCKED if line count = V_TOTAL and the bad flag is clear, else clear the flag and remain in MEASURE.
REQ-023 LOCKED: a line length other than H_TOTAL or a frame line count other than V_TOTAL SHALL pulse sync_err and go to MEASURE in the same tick.
REQ-024 From any state, h_cnt reaching 2*H_TOTAL (no hsync edge) SHALL force SEARCH without sync_err; this takes priority over REQ-022/023.
REQ-025 Simultaneous hsync and vsync falling edges SHALL be treated as vsync arming then hsync processing in that tick (v_cnt=0).
REQ-026 locked SHALL equal (state==LOCKED), registered.

Reset
REQ-027 With rst_n=0: state=SEARCH; counters, flags and input registers=0 (sync registers=1); x=y=0; colour=0; pix_valid=frame_start=locked=sync_err=0.
REQ-028 Reset asserted mid-frame SHALL take effect immediately; after release, lock requires a full MEASURE frame again.

Structure
REQ-029 Timing defaults and FSM state encoding SHALL live in shared package vga_timing_pkg, reused by the existing sync generator.
REQ-030 Edge detection SHALL be one sub-module, vga_edge_detect (registered input, falling-edge pulse, pix_en qualified), instantiated for hsync and vsync.

Verification
REQ-031 Drive two clean 800x525 frames from the team's sync generator -> locked=1 at the start of frame 2 (second vsync falling edge); frame 3 delivers 307200 pix_valid pixels, first with x=0,y=0,frame_start=1, last x=639,y=479.
REQ-032 Locked, one line shortened to 799 pixels -> sync_err one tick, locked=0 next tick, locked=1 again after one clean frame.
REQ-033 Hold hsync_in high 1600 pix_en ticks -> state SEARCH, locked=0, sync_err stays 0.
REQ-034 Colour ramp red_in=h_cnt[7:0] -> red out equals pixel sampled one pix_en tick earlier; 0 in blanking.
REQ-035 pix_en high every 4th clk -> outputs change only on pix_en edges; results identical to REQ-031.
REQ-036 rst_n low mid-line in LOCKED -> all outputs 0 asynchronously; relock after release needs one full frame.
